serial_subtractor: RTL and testbench

//  Multi-cycle bit-serial subtractor: diff = a - b (mod 2^WIDTH) plus unsigned borrow-out.

---
 rtl/serial_sub_pkg.sv | 25 ++
 rtl/serial_subtractor_if.sv | 57 +++++
 rtl/full_subtractor.sv | 24 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared state encoding and sizing helpers for serial_subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; a 1-bit floor keeps tiny widths legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Operand/result handshake bundle for serial_subtractor.
//                overflow exists only when SERIAL_SUB_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;
`endif

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  diff,
`ifdef SERIAL_SUB_OVF_EN
        input  overflow,
`endif
        input  borrow_out
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output diff,
`ifdef SERIAL_SUB_OVF_EN
        output overflow,
`endif
        output borrow_out
    );

endinterface : serial_subtractor_if

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit combinational full subtractor (a - b - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_x;

    assign w_x  = a ^ b;
    assign d    = w_x ^ bin;
    assign bout = (~a & b) | (~w_x & bin);

endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor, LSB first, one bit per clock.
//                Define SERIAL_SUB_OVF_EN to add the signed overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int             CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_bout;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == c_last_bit);

    full_subtractor u_full_subtractor (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // The borrow FF doubles as borrow_out: its last update is the final bout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_borrow <= w_bout;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit r_a[0]/r_b[0] are the sign bits and w_d is diff's sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_ovf <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
        end
    end

    assign bus.overflow = r_ovf;
`endif

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow;

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor against an
//                arithmetic reference (overflow checked with SERIAL_SUB_OVF_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W    = DEFAULT_WIDTH;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int ref_diff(input int x, input int y);
        return (x - y) & MASK;
    endfunction

    function automatic int ref_borrow(input int x, input int y);
        return (x < y) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int x, input int y);
        int sx, sy, r;
        sx = (x >= HALF) ? x - (1 << W) : x;
        sy = (y >= HALF) ? y - (1 << W) : y;
        r  = sx - sy;
        return (r < -HALF || r > HALF - 1) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int x, input int y);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a        = x[W-1:0];
        bus.b        = y[W-1:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input int x, input int y);
        chk("diff", 32'(bus.diff), 32'(ref_diff(x, y)));
        chk("borrow_out", 32'(bus.borrow_out), 32'(ref_borrow(x, y)));
`ifdef SERIAL_SUB_OVF_EN
        chk("overflow", 32'(bus.overflow), 32'(ref_ovf(x, y)));
`endif
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("out_valid_after_ack", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after_ack", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input int x, input int y);
        int lat;
        start_op(x, y);
        wait_done(lat);
        chk("latency", 32'(lat), 32'(W));
        check_result(x, y);
        release_result();
    endtask

    initial begin
        int lat;
        int x, y;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner values.
        run_op(9, 3);
        run_op(3, 9);
        run_op(0, 0);
        run_op(15, 15);
        run_op(0, 1);

        // Back-pressure in DONE with in_valid pulses that must be ignored.
        start_op(9, 3);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'(W));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = (k % 2 == 0);
            bus.a        = 4'd1;
            bus.b        = 4'd2;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_diff", 32'(bus.diff), 32'd6);
            chk("bp_borrow", 32'(bus.borrow_out), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_result();
        chk("bp_no_capture_diff", 32'(bus.diff), 32'd6);
        @(posedge clk);
        #1 chk("bp_still_idle", 32'(bus.in_ready), 32'd1);

        // Reset after bits 0 and 1 have been processed.
        start_op(6, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_overflow", 32'(bus.overflow), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op(5, 2);

`ifdef SERIAL_SUB_OVF_EN
        run_op(8, 1);
        chk("ovf_8_1", 32'(bus.overflow), 32'd1);
        run_op(7, 1);
        chk("ovf_7_1", 32'(bus.overflow), 32'd0);
`endif

        // Random operands.
        for (int n = 0; n < 24; n++) begin
            x = int'($urandom_range(MASK, 0));
            y = int'($urandom_range(MASK, 0));
            run_op(x, y);
        end

        // Full operand sweep.
        for (int i = 0; i <= MASK; i++) begin
            for (int j = 0; j <= MASK; j++) begin
                run_op(i, j);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor

`default_nettype wire
